tx_packet_arbiter: RTL and testbench

//  Packet-level arbiter in front of the Tx controller write port (length counter -> FIFO -> block-token insertion).

---
 rtl/tx_packet_arbiter.sv | 112 +++++++++++
 tb/tb_tx_packet_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_packet_arbiter.sv
// tx_packet_arbiter: packet-level arbiter sharing the Tx controller write port between
// replay (0), DLLP (1) and TLP (2) sources, with a TLP starvation guard and full backpressure.
module tx_packet_arbiter #(
    parameter int DATA_W       = 512,
    parameter int BYTE_W       = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  tx_enable,
    input  logic [2:0]            req_valid,
    input  logic [2:0]            req_last,
    input  logic [3*DATA_W-1:0]   req_data,
    input  logic [3*BYTE_W-1:0]   req_bvalid,
    input  logic [3*BYTE_W-1:0]   req_stp,
    input  logic [3*BYTE_W-1:0]   req_sdp,
    input  logic [3*BYTE_W-1:0]   req_end,
    output logic [2:0]            req_ready,
    input  logic                  full,
    output logic                  wr,
    output logic [DATA_W-1:0]     data_out,
    output logic [BYTE_W-1:0]     wr_valid,
    output logic [BYTE_W-1:0]     stp_out,
    output logic [BYTE_W-1:0]     sdp_out,
    output logic [BYTE_W-1:0]     end_out,
    output logic [1:0]            grant_id,
    output logic                  busy
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   starve_cnt;
    logic [1:0]         winner;
    logic               arb, out_ready, accept, done;
    logic               sel_valid, sel_last;
    logic [DATA_W-1:0]  sel_data;
    logic [BYTE_W-1:0]  sel_bvalid, sel_stp, sel_sdp, sel_end;

    assign out_ready = !wr || !full;
    assign arb       = state == IDLE && tx_enable && |req_valid;
    assign accept    = state == BUSY && sel_valid && out_ready;
    assign done      = accept && sel_last;

    // Replay always first; a waiting TLP overrides DLLP once the starvation limit is hit
    always_comb winner = req_valid[0] ? 2'd0 :
                         (req_valid[2] && starve_cnt == LIMIT) ? 2'd2 :
                         req_valid[1] ? 2'd1 : 2'd2;

    always_comb begin
        sel_valid  = grant_id == 2'd0 ? req_valid[0] : grant_id == 2'd1 ? req_valid[1] : req_valid[2];
        sel_last   = grant_id == 2'd0 ? req_last[0]  : grant_id == 2'd1 ? req_last[1]  : req_last[2];
        sel_data   = grant_id == 2'd0 ? req_data[0 +: DATA_W] :
                     grant_id == 2'd1 ? req_data[DATA_W +: DATA_W] : req_data[2*DATA_W +: DATA_W];
        sel_bvalid = grant_id == 2'd0 ? req_bvalid[0 +: BYTE_W] :
                     grant_id == 2'd1 ? req_bvalid[BYTE_W +: BYTE_W] : req_bvalid[2*BYTE_W +: BYTE_W];
        sel_stp    = grant_id == 2'd0 ? req_stp[0 +: BYTE_W] :
                     grant_id == 2'd1 ? req_stp[BYTE_W +: BYTE_W] : req_stp[2*BYTE_W +: BYTE_W];
        sel_sdp    = grant_id == 2'd0 ? req_sdp[0 +: BYTE_W] :
                     grant_id == 2'd1 ? req_sdp[BYTE_W +: BYTE_W] : req_sdp[2*BYTE_W +: BYTE_W];
        sel_end    = grant_id == 2'd0 ? req_end[0 +: BYTE_W] :
                     grant_id == 2'd1 ? req_end[BYTE_W +: BYTE_W] : req_end[2*BYTE_W +: BYTE_W];
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb state_nxt = arb ? BUSY : done ? IDLE : state;

    always_comb begin
        busy      = state == BUSY;
        req_ready = (busy && out_ready) ? 3'b001 << grant_id : 3'b000;
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            grant_id   <= 2'd3;
            starve_cnt <= '0;
        end else if (arb) begin
            grant_id   <= winner;
            starve_cnt <= winner == 2'd2 ? '0 :
                          (winner == 2'd1 && req_valid[2] && starve_cnt != LIMIT) ? starve_cnt + CNT_W'(1) :
                          starve_cnt;
        end else if (done) begin
            grant_id   <= 2'd3;
        end
    end

    // Single output register: holds everything while a write is stalled by full
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            wr       <= 1'b0;
            data_out <= '0;
            wr_valid <= '0;
            stp_out  <= '0;
            sdp_out  <= '0;
            end_out  <= '0;
        end else if (accept) begin
            wr       <= 1'b1;
            data_out <= sel_data;
            wr_valid <= sel_bvalid;
            stp_out  <= sel_stp;
            sdp_out  <= sel_sdp;
            end_out  <= sel_end;
        end else if (out_ready) begin
            wr       <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tx_packet_arbiter.sv
// tb_tx_packet_arbiter: table vectors for arbitration, directed multi-cycle sequences,
// and randomized traffic scored against a packet-order model of the arbitration rules.
module tb_tx_packet_arbiter;
    localparam int DATA_W = 512;
    localparam int BYTE_W = 64;
    localparam int LIMIT  = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [BYTE_W-1:0] bv, stp, sdp, en;
        logic              first, last;
    } beat_t;

    typedef struct {
        logic       ten;
        logic [2:0] valid;
        logic [1:0] grant;
        logic       busy;
        logic [2:0] ready;
    } vec_t;

    logic                pclk = 0, reset = 0, tx_enable = 0, full = 0;
    logic [2:0]          req_valid = 0, req_last = 0, req_ready;
    logic [3*DATA_W-1:0] req_data = 0;
    logic [3*BYTE_W-1:0] req_bvalid = 0, req_stp = 0, req_sdp = 0, req_end = 0;
    logic                wr, busy;
    logic [DATA_W-1:0]   data_out;
    logic [BYTE_W-1:0]   wr_valid, stp_out, sdp_out, end_out;
    logic [1:0]          grant_id;

    beat_t      src_q[3][$];
    beat_t      mq[3][$];
    int         plen[3][$];
    beat_t      exp_q[$];
    logic [2:0] acc = 0;
    int         m_cnt = 0;
    bit         rnd_en = 0, full_force = 0;
    int         n_cmp = 0, n_bad = 0;

    tx_packet_arbiter dut (
        .pclk(pclk), .reset(reset), .tx_enable(tx_enable),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_bvalid(req_bvalid), .req_stp(req_stp), .req_sdp(req_sdp), .req_end(req_end),
        .req_ready(req_ready), .full(full), .wr(wr), .data_out(data_out),
        .wr_valid(wr_valid), .stp_out(stp_out), .sdp_out(sdp_out), .end_out(end_out),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic beat_t mk_beat(bit first, bit last);
        beat_t b;
        for (int w = 0; w < DATA_W / 32; w++) b.data[w*32 +: 32] = $urandom;
        b.bv  = {$urandom, $urandom};
        b.stp = {$urandom, $urandom};
        b.sdp = {$urandom, $urandom};
        b.en  = {$urandom, $urandom};
        b.first = first;
        b.last  = last;
        return b;
    endfunction

    task automatic add_pkt(int s, int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = mk_beat(i == 0, i == len - 1);
            src_q[s].push_back(b);
            mq[s].push_back(b);
        end
        plen[s].push_back(len);
    endtask

    // Every pending source presents its packet head whenever the arbiter is idle,
    // so the delivery order follows from the pending packet lists alone.
    task automatic plan();
        int w, n;
        while (plen[0].size() + plen[1].size() + plen[2].size() > 0) begin
            if (plen[0].size() > 0) w = 0;
            else if (plen[2].size() > 0 && m_cnt == LIMIT) w = 2;
            else if (plen[1].size() > 0) w = 1;
            else w = 2;
            if (w == 2) m_cnt = 0;
            else if (w == 1 && plen[2].size() > 0 && m_cnt < LIMIT) m_cnt++;
            n = plen[w].pop_front();
            repeat (n) exp_q.push_back(mq[w].pop_front());
        end
    endtask

    task automatic clear_all();
        for (int s = 0; s < 3; s++) begin
            src_q[s].delete();
            mq[s].delete();
            plen[s].delete();
        end
        exp_q.delete();
        acc = 0;
        m_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge pclk);
        reset = 1;
        clear_all();
        tx_enable = 1;
        req_valid = 0;
        req_last = 0;
        full = 0;
        full_force = 0;
        @(negedge pclk);
        reset = 0;
    endtask

    task automatic check_out();
        beat_t b;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: got write data[63:0]=%0h expected no write", data_out[63:0]);
        end else begin
            b = exp_q.pop_front();
            if ({data_out, wr_valid, stp_out, sdp_out, end_out} !== {b.data, b.bv, b.stp, b.sdp, b.en}) begin
                n_bad++;
                $display("FAIL beat: got data[63:0]=%0h bv=%0h end=%0h expected data[63:0]=%0h bv=%0h end=%0h",
                         data_out[63:0], wr_valid, end_out, b.data[63:0], b.bv, b.en);
            end
        end
    endtask

    // One clock: retire accepted beats, drive the next heads, then sample at the falling edge
    task automatic cycle();
        beat_t b;
        @(posedge pclk);
        #1;
        for (int s = 0; s < 3; s++) if (acc[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
        full = rnd_en ? ($urandom_range(0, 2) == 0) : full_force;
        for (int s = 0; s < 3; s++) begin
            if (src_q[s].size() > 0) begin
                b = src_q[s][0];
                req_valid[s] = b.first || !rnd_en || ($urandom_range(0, 3) != 0);
                req_last[s] = b.last;
                req_data[s*DATA_W +: DATA_W] = b.data;
                req_bvalid[s*BYTE_W +: BYTE_W] = b.bv;
                req_stp[s*BYTE_W +: BYTE_W] = b.stp;
                req_sdp[s*BYTE_W +: BYTE_W] = b.sdp;
                req_end[s*BYTE_W +: BYTE_W] = b.en;
            end else begin
                req_valid[s] = 0;
                req_last[s] = 0;
            end
        end
        @(negedge pclk);
        acc = req_valid & req_ready;
        if (wr && !full) check_out();
    endtask

    task automatic drain(string name, int maxc);
        int c = 0;
        while (exp_q.size() > 0 && c < maxc) begin
            cycle();
            c++;
        end
        chk({name, "_left"}, exp_q.size(), 0);
        repeat (2) cycle();
    endtask

    initial begin
        vec_t tv[8];
        int sexp[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
        int gl[$];
        logic [5:0] wrlog;
        logic [9:0] bl;
        logic [5:0] gseq;
        logic [1:0] g1;
        logic [DATA_W-1:0] snap;
        logic pb;
        int c;

        #2 reset = 1;
        #1;
        chk("rst_wr", wr, 0);
        chk("rst_grant", grant_id, 3);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_data_zero", data_out == '0, 1);
        chk("rst_markers", {wr_valid, stp_out}, 0);

        tv[0] = '{1'b1, 3'b111, 2'd0, 1'b1, 3'b001};
        tv[1] = '{1'b1, 3'b110, 2'd1, 1'b1, 3'b010};
        tv[2] = '{1'b1, 3'b100, 2'd2, 1'b1, 3'b100};
        tv[3] = '{1'b1, 3'b010, 2'd1, 1'b1, 3'b010};
        tv[4] = '{1'b1, 3'b101, 2'd0, 1'b1, 3'b001};
        tv[5] = '{1'b0, 3'b111, 2'd3, 1'b0, 3'b000};
        tv[6] = '{1'b1, 3'b000, 2'd3, 1'b0, 3'b000};
        tv[7] = '{1'b1, 3'b001, 2'd0, 1'b1, 3'b001};
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            reset = 1;
            req_valid = tv[i].valid;
            req_last = 3'b111;
            tx_enable = tv[i].ten;
            full = 0;
            #1 reset = 0;
            @(posedge pclk);
            #1;
            chk("tbl_grant", grant_id, tv[i].grant);
            chk("tbl_busy", busy, tv[i].busy);
            chk("tbl_ready", req_ready, tv[i].ready);
        end

        do_reset();
        add_pkt(2, 3);
        plan();
        for (int i = 0; i < 6; i++) begin
            cycle();
            wrlog[i] = wr;
            if (i == 1) g1 = grant_id;
        end
        chk("tlp_wr_timing", wrlog, 6'b011100);
        chk("tlp_grant", g1, 2);
        drain("tlp", 20);

        do_reset();
        add_pkt(0, 2);
        add_pkt(1, 2);
        add_pkt(2, 2);
        plan();
        for (int i = 0; i < 10; i++) begin
            cycle();
            bl[i] = busy;
            if (i == 1) gseq[5:4] = grant_id;
            if (i == 4) gseq[3:2] = grant_id;
            if (i == 7) gseq[1:0] = grant_id;
        end
        chk("order_busy", bl, 10'b0110110110);
        chk("order_grants", gseq, 6'b00_01_10);
        drain("order", 30);

        do_reset();
        repeat (10) add_pkt(1, 1);
        repeat (4) add_pkt(2, 1);
        plan();
        pb = 0;
        c = 0;
        while (gl.size() < 10 && c < 60) begin
            cycle();
            if (busy && !pb) gl.push_back(int'(grant_id));
            pb = busy;
            c++;
        end
        for (int i = 0; i < 10; i++) chk("starve_grant", i < gl.size() ? gl[i] : 99, sexp[i]);
        drain("starve", 80);

        do_reset();
        add_pkt(2, 6);
        plan();
        c = 0;
        while (!wr && c < 20) begin
            cycle();
            c++;
        end
        cycle();
        full_force = 1;
        cycle();
        snap = data_out;
        for (int i = 0; i < 5; i++) begin
            chk("stall_wr", wr, 1);
            chk("stall_ready", req_ready, 0);
            chk("stall_data_stable", data_out == snap, 1);
            if (i < 4) cycle();
        end
        full_force = 0;
        drain("stall", 40);

        do_reset();
        tx_enable = 0;
        add_pkt(1, 3);
        plan();
        repeat (4) begin
            cycle();
            chk("ten_off_grant", grant_id, 3);
            chk("ten_off_ready", req_ready, 0);
        end
        tx_enable = 1;
        c = 0;
        while (!busy && c < 10) begin
            cycle();
            c++;
        end
        cycle();
        tx_enable = 0;
        drain("ten_drop", 40);
        add_pkt(1, 2);
        plan();
        repeat (4) begin
            cycle();
            chk("ten_hold_busy", busy, 0);
            chk("ten_hold_grant", grant_id, 3);
        end
        tx_enable = 1;
        drain("ten_resume", 40);

        do_reset();
        add_pkt(2, 4);
        plan();
        c = 0;
        while (!wr && c < 20) begin
            cycle();
            c++;
        end
        cycle();
        #2 reset = 1;
        #1;
        chk("mid_rst_wr", wr, 0);
        chk("mid_rst_grant", grant_id, 3);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_data_zero", data_out == '0, 1);
        chk("mid_rst_markers", {wr_valid, end_out}, 0);
        clear_all();
        add_pkt(2, 4);
        plan();
        cycle();
        reset = 0;
        drain("restart", 40);

        do_reset();
        rnd_en = 1;
        for (int s = 0; s < 3; s++) begin
            c = $urandom_range(4, 8);
            repeat (c) add_pkt(s, $urandom_range(1, 4));
        end
        plan();
        drain("random", 6000);
        rnd_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
